// File: rtl/fifo_ctrl_pkg.sv
// Shared defaults and head-stage state encodings for the FIFO RAM controller.
// Used by fifo_ptr and fifo_ram_ctrl (optional flush feature: FIFO_FLUSH_EN).
package fifo_ctrl_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int ADDR_W_DEF   = 11;
    localparam int AF_LEVEL_DEF = 2040;

    typedef enum logic [1:0] {
        HEAD_EMPTY = 2'd0,
        HEAD_PEND  = 2'd1,
        HEAD_HOLD  = 2'd2
    } head_state_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping RAM address pointer with increment enable and a synchronous load.
// The load is only driven when FIFO_FLUSH_EN is defined in the top.
module fifo_ptr
    import fifo_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] ptr
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;

    // Natural wrap from 2**ADDR_W-1 back to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ram_ctrl.sv
// Single-clock FIFO controller for a dual-port RAM with a 1-cycle registered read,
// presenting a show-ahead head stage. Optional synchronous flush port: FIFO_FLUSH_EN.
module fifo_ram_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int AF_LEVEL = AF_LEVEL_DEF
) (
    input  logic              clk,
    input  logic              reset,
`ifdef FIFO_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              push_valid,
    output logic              push_ready,
    input  logic [DATA_W-1:0] push_data,
    output logic              pop_valid,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] pop_data,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
    output logic              ram_w_en,
    output logic [ADDR_W-1:0] ram_w_adrs,
    output logic [DATA_W-1:0] ram_w_data,
    output logic              ram_r_en,
    output logic [ADDR_W-1:0] ram_r_adrs,
    input  logic [DATA_W-1:0] ram_r_data,
    output logic              ram_full,
    output logic              ram_empty
);

    typedef logic [ADDR_W:0] cnt_t;

    localparam cnt_t DEPTH  = {1'b1, {ADDR_W{1'b0}}};
    localparam cnt_t AF_CNT = cnt_t'(AF_LEVEL);

    // Handshake: a transfer happens on every rising clk edge where valid and ready
    // are both high; push_ready and pop_valid never depend on push_valid/pop_ready.
    logic              flush_w;
    logic              push_fire;
    logic              pop_fire;
    logic              r_en;
    cnt_t              mem_cnt_q, mem_cnt_d;
    head_state_e       state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] wptr, rptr;

`ifdef FIFO_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
        .clk      (clk),
        .rst      (reset),
        .inc      (push_fire),
        .load     (flush_w),
        .load_val (rptr),
        .ptr      (wptr)
    );

    fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
        .clk      (clk),
        .rst      (reset),
        .inc      (r_en),
        .load     (1'b0),
        .load_val ('0),
        .ptr      (rptr)
    );

    // Head-stage state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= HEAD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head-stage next state; a fresh read always wins over hold/empty transitions.
    always_comb begin
        state_d = state_q;
        if (flush_w) begin
            state_d = HEAD_EMPTY;
        end else if (r_en) begin
            state_d = HEAD_PEND;
        end else if (state_q == HEAD_PEND && !pop_fire) begin
            state_d = HEAD_HOLD;
        end else if (pop_fire) begin
            state_d = HEAD_EMPTY;
        end
    end

    // Head-stage and write-side outputs.
    always_comb begin
        push_ready = (mem_cnt_q != DEPTH) && !flush_w;
        push_fire  = push_valid && push_ready;
        pop_valid  = (state_q != HEAD_EMPTY);
        pop_fire   = pop_valid && pop_ready;
        r_en       = (mem_cnt_q != '0) && (state_q == HEAD_EMPTY || pop_fire) && !flush_w;
        pop_data   = (state_q == HEAD_PEND) ? ram_r_data : hold_q;
    end

    // mem_cnt tracks only committed writes, so a read never hits the word being written.
    always_comb begin
        mem_cnt_d = mem_cnt_q;
        hold_d    = hold_q;
        if (flush_w) begin
            mem_cnt_d = '0;
        end else if (push_fire && !r_en) begin
            mem_cnt_d = mem_cnt_q + cnt_t'(1);
        end else if (!push_fire && r_en) begin
            mem_cnt_d = mem_cnt_q - cnt_t'(1);
        end
        if (state_q == HEAD_PEND && state_d == HEAD_HOLD) begin
            hold_d = ram_r_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cnt_q <= '0;
            hold_q    <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            hold_q    <= hold_d;
        end
    end

    assign count       = mem_cnt_q + cnt_t'(pop_valid);
    assign almost_full = (count >= AF_CNT);
    assign ram_w_en    = push_fire;
    assign ram_w_adrs  = wptr;
    assign ram_w_data  = push_data;
    assign ram_r_en    = r_en;
    assign ram_r_adrs  = rptr;
    assign ram_full    = 1'b0;
    assign ram_empty   = 1'b0;

endmodule

// File: tb/tb_fifo_ram_ctrl.sv
// Self-checking bench for fifo_ram_ctrl with a behavioural RAM and a queue-based
// reference model; flush scenarios are included when FIFO_FLUSH_EN is defined.
module tb_fifo_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int AF    = 2040;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_valid, push_ready, pop_valid, pop_ready, almost_full;
    logic          ram_w_en, ram_r_en, ram_full, ram_empty;
    logic [DW-1:0] push_data, pop_data, ram_w_data, ram_r_data;
    logic [AW-1:0] ram_w_adrs, ram_r_adrs;
    logic [AW:0]   count;
`ifdef FIFO_FLUSH_EN
    logic          flush;
`endif

    always #5 clk = ~clk;

    fifo_ram_ctrl dut (
        .clk         (clk),
        .reset       (reset),
`ifdef FIFO_FLUSH_EN
        .flush       (flush),
`endif
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_data   (push_data),
        .pop_valid   (pop_valid),
        .pop_ready   (pop_ready),
        .pop_data    (pop_data),
        .count       (count),
        .almost_full (almost_full),
        .ram_w_en    (ram_w_en),
        .ram_w_adrs  (ram_w_adrs),
        .ram_w_data  (ram_w_data),
        .ram_r_en    (ram_r_en),
        .ram_r_adrs  (ram_r_adrs),
        .ram_r_data  (ram_r_data),
        .ram_full    (ram_full),
        .ram_empty   (ram_empty)
    );

    // Behavioural 2048x32 RAM with a registered read port.
    logic [DW-1:0] ram_mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
        ram_r_data = '0;
    end
    always @(posedge clk) begin
        if (ram_w_en) ram_mem[ram_w_adrs] <= ram_w_data;
        if (ram_r_en) ram_r_data <= ram_mem[ram_r_adrs];
    end

    // Reference model: words held, the cycle each was pushed, and the last pop cycle.
    logic [DW-1:0] exp_q[$];
    int            exp_t_q[$];
    int            last_pop;
    int            cyc;
    int            w_ptr_m;
    int            n_checks;
    int            n_err;
    bit            chk_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_t_q.delete();
        last_pop = -100;
        w_ptr_m  = 0;
    endtask

    // Head visible at cycle c when pushed at or before c-2 and the previous head left at or before c-1.
    always @(negedge clk) begin
        if (!reset && chk_en) begin
            bit pv, pr, wf, pf, fl;
            int vt, sz;
            fl = 1'b0;
`ifdef FIFO_FLUSH_EN
            fl = flush;
`endif
            sz = exp_q.size();
            pv = 1'b0;
            if (sz > 0) begin
                vt = exp_t_q[0] + 2;
                if (last_pop + 1 > vt) vt = last_pop + 1;
                pv = (cyc >= vt);
            end
            pr = ((sz - int'(pv)) != DEPTH) && !fl;
            wf = push_valid && pr;
            pf = pv && pop_ready;
            chk("pop_valid", 64'(pop_valid), 64'(pv));
            chk("count", 64'(count), 64'(sz));
            chk("push_ready", 64'(push_ready), 64'(pr));
            chk("almost_full", 64'(almost_full), 64'(sz >= AF));
            if (pv) chk("pop_data", 64'(pop_data), 64'(exp_q[0]));
            chk("ram_w_en", 64'(ram_w_en), 64'(wf));
            if (wf) begin
                chk("ram_w_adrs", 64'(ram_w_adrs), 64'(w_ptr_m));
                chk("ram_w_data", 64'(ram_w_data), 64'(push_data));
            end
            chk("ram_full_empty", 64'({ram_full, ram_empty}), 64'(0));
            if (fl) begin
                w_ptr_m = (w_ptr_m - (sz - int'(pv)) + DEPTH) % DEPTH;
                exp_q.delete();
                exp_t_q.delete();
                last_pop = -100;
            end else begin
                if (pf) begin
                    void'(exp_q.pop_front());
                    void'(exp_t_q.pop_front());
                    last_pop = cyc;
                end
                if (wf) begin
                    exp_q.push_back(push_data);
                    exp_t_q.push_back(cyc);
                    w_ptr_m = (w_ptr_m + 1) % DEPTH;
                end
            end
            cyc++;
        end
    end

    task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pr);
        @(posedge clk);
        #1;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
    endtask

    task automatic drain();
        for (int k = 0; k < 5000; k++) begin
            drive(1'b0, '0, 1'b1);
            @(negedge clk);
            if (count == 0) break;
        end
        chk("drain_empty", 64'(count), 64'(0));
        drive(1'b0, '0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_push_ready"}, 64'(push_ready), 64'(1));
        chk({tag, "_pop_valid"}, 64'(pop_valid), 64'(0));
        chk({tag, "_count"}, 64'(count), 64'(0));
        chk({tag, "_almost_full"}, 64'(almost_full), 64'(0));
        chk({tag, "_ram_w_en"}, 64'(ram_w_en), 64'(0));
        chk({tag, "_ram_r_en"}, 64'(ram_r_en), 64'(0));
        chk({tag, "_pop_data"}, 64'(pop_data), 64'(0));
    endtask

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: run did not complete (t=%0t)", $time);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

    initial begin
        n_checks   = 0;
        n_err      = 0;
        chk_en     = 1'b0;
        cyc        = 0;
        push_valid = 1'b0;
        push_data  = '0;
        pop_ready  = 1'b0;
`ifdef FIFO_FLUSH_EN
        flush      = 1'b0;
`endif
        model_clear();
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        #2 reset = 1'b0;
        chk_en = 1'b1;

        // Single word: visible two cycles after the push cycle.
        drive(1'b1, 32'hA5A5_0001, 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t1_pop_valid_c1", 64'(pop_valid), 64'(0));
        chk("t1_count_c1", 64'(count), 64'(1));
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t1_pop_valid_c2", 64'(pop_valid), 64'(1));
        chk("t1_pop_data_c2", 64'(pop_data), 64'(32'hA5A5_0001));
        chk("t1_count_c2", 64'(count), 64'(1));
        drive(1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0);

        // Streaming push and pop.
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, DW'(i), 1'b1);
            @(negedge clk);
            chk("t2_count_le2", 64'(count <= 2), 64'(1));
        end
        drain();

        // Fill past RAM capacity with the consumer stalled.
        for (int i = 0; i < 2049; i++) drive(1'b1, DW'(32'h3000_0000 + i), 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t3_count_full", 64'(count), 64'(2049));
        chk("t3_push_ready_full", 64'(push_ready), 64'(0));
        chk("t3_almost_full", 64'(almost_full), 64'(1));
        drive(1'b1, 32'hF00D_0001, 1'b0);
        @(negedge clk);
        chk("t3_push_blocked", 64'(push_ready), 64'(0));
        drive(1'b1, 32'hF00D_0001, 1'b1);
        drive(1'b1, 32'hF00D_0002, 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t3_count_refilled", 64'(count), 64'(2049));
        chk("t3_push_ready_again0", 64'(push_ready), 64'(0));
        drain();

        // Fill, drain, refill across the pointer wrap.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 2048; i++) drive(1'b1, DW'(32'h4000_0000 + r * 32'h0010_0000 + i), 1'b0);
            drive(1'b0, '0, 1'b0);
            @(negedge clk);
            chk("t4_count_2048", 64'(count), 64'(2048));
            chk("t4_push_ready_2048", 64'(push_ready), 64'(1));
            drain();
        end

        // Stall while the head is pending: held word must stay put.
        drive(1'b1, 32'hC0DE_0005, 1'b0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, '0, 1'b0);
            @(negedge clk);
            if (i >= 1) begin
                chk("t5_hold_valid", 64'(pop_valid), 64'(1));
                chk("t5_hold_data", 64'(pop_data), 64'(32'hC0DE_0005));
            end
        end
        drain();

        // Reset with words queued.
        for (int i = 0; i < 10; i++) drive(1'b1, DW'(32'h6000_0000 + i), 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        chk("t6_count_before", 64'(count), 64'(10));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_reset_values("t6_reset");
        model_clear();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        chk("t6_count_after", 64'(count), 64'(0));
        chk("t6_pop_valid_after", 64'(pop_valid), 64'(0));
        drive(1'b1, 32'h6666_0001, 1'b0);
        drain();

`ifdef FIFO_FLUSH_EN
        for (int i = 0; i < 10; i++) drive(1'b1, DW'(32'h7000_0000 + i), 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        flush      = 1'b1;
        push_valid = 1'b1;
        push_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("flush_push_ready", 64'(push_ready), 64'(0));
        chk("flush_ram_w_en", 64'(ram_w_en), 64'(0));
        @(posedge clk);
        #1;
        flush      = 1'b0;
        push_valid = 1'b0;
        @(negedge clk);
        chk("flush_count_after", 64'(count), 64'(0));
        chk("flush_pop_valid_after", 64'(pop_valid), 64'(0));
        drive(1'b1, 32'h7777_0001, 1'b0);
        drain();
`endif

        // Randomized traffic with varying push/pop pressure.
        for (int b = 0; b < 8; b++) begin
            int p_push, p_pop;
            p_push = $urandom_range(20, 100);
            p_pop  = $urandom_range(0, 100);
            if (b == 2) p_pop = 5;
            for (int i = 0; i < 500; i++) begin
                drive($urandom_range(0, 99) < p_push, $urandom, $urandom_range(0, 99) < p_pop);
            end
        end
        drain();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
